// File: rtl/ps2_debouncer.sv
// Two-channel PS/2 glitch filter: each output follows its input only after CNT_MAX stable cycles.
// Define DEBOUNCER_SYNC_EN to insert a 2-flop synchronizer ahead of each channel's counter.
module ps2_debouncer #(
    parameter int unsigned CNT_MAX = 19,
    parameter int unsigned CNT_W   = 5,
    parameter bit          RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic I0,
    input  logic I1,
    output logic O0,
    output logic O1
);

    localparam int unsigned NCH = 2;

    logic [NCH-1:0]            samp;
    logic [NCH-1:0]            out_q, out_d;
    logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;

`ifdef DEBOUNCER_SYNC_EN
    logic [NCH-1:0] sync1_q, sync2_q;

    // Synchronizer resets to the idle level so release does not look like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= {NCH{RST_VAL}};
            sync2_q <= {NCH{RST_VAL}};
        end else begin
            sync1_q <= {I1, I0};
            sync2_q <= sync1_q;
        end
    end

    assign samp = sync2_q;
`else
    assign samp = {I1, I0};
`endif

    // Per-channel stability counter; any matching sample discards partial progress.
    always_comb begin
        out_d = out_q;
        cnt_d = cnt_q;
        for (int i = 0; i < int'(NCH); i++) begin
            if (samp[i] == out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(CNT_MAX - 1)) begin
                out_d[i] = samp[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= {NCH{RST_VAL}};
            cnt_q <= '0;
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end

    assign O0 = out_q[0];
    assign O1 = out_q[1];

endmodule

// File: tb/tb_ps2_debouncer.sv
// Directed bench for ps2_debouncer; latency expectations adapt when DEBOUNCER_SYNC_EN is defined.
module tb_ps2_debouncer;

    localparam int unsigned CNT_MAX = 19;
`ifdef DEBOUNCER_SYNC_EN
    localparam int LAT = CNT_MAX + 2;
`else
    localparam int LAT = CNT_MAX;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic I0, I1;
    logic O0, O1;

    int n_chk  = 0;
    int n_pass = 0;
    logic o0_low, o1_low;

    ps2_debouncer #(.CNT_MAX(CNT_MAX), .CNT_W(5), .RST_VAL(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .I0    (I0),
        .I1    (I1),
        .O0    (O0),
        .O1    (O1)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    // Advance n cycles, sampling at each falling edge and latching any low output.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (O0 !== 1'b1) o0_low = 1'b1;
            if (O1 !== 1'b1) o1_low = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b1;
        I0 = 1'b0;
        I1 = 1'b0;
        o0_low = 1'b0;
        o1_low = 1'b0;

        // 1. Reset forces idle-high with no clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_o0", O0, 1'b1);
        chk("rst_o1", O1, 1'b1);
        I0 = 1'b1;
        I1 = 1'b1;
        step(3);
        rst_n = 1'b1;
        o0_low = 1'b0;
        o1_low = 1'b0;
        step(LAT + 5);
        chk("rel_o0_stay", o0_low, 1'b0);
        chk("rel_o1_stay", o1_low, 1'b0);

        // 2. Clean falling edge on channel 0.
        I0 = 1'b0;
        step(LAT - 1);
        chk("edge_o0_pre", O0, 1'b1);
        step(1);
        chk("edge_o0_fall", O0, 1'b0);
        chk("edge_o1_hold", O1, 1'b1);
        I0 = 1'b1;
        step(LAT - 1);
        chk("rise_o0_pre", O0, 1'b0);
        step(1);
        chk("rise_o0_up", O0, 1'b1);

        // 3. Glitches on channel 1 are rejected.
        o1_low = 1'b0;
        I1 = 1'b0;
        step(CNT_MAX - 1);
        I1 = 1'b1;
        step(LAT + 2);
        chk("glitch18_o1", o1_low, 1'b0);
        I1 = 1'b0;
        step(10);
        I1 = 1'b1;
        step(1);
        I1 = 1'b0;
        step(CNT_MAX - 1);
        I1 = 1'b1;
        step(LAT + 2);
        chk("glitch_restart_o1", o1_low, 1'b0);

        // 4. Simultaneous edges, then channel 0 bounces back.
        I0 = 1'b0;
        I1 = 1'b0;
        step(LAT - 1);
        chk("sim_o0_pre", O0, 1'b1);
        chk("sim_o1_pre", O1, 1'b1);
        step(1);
        chk("sim_o0_fall", O0, 1'b0);
        chk("sim_o1_fall", O1, 1'b0);
        I0 = 1'b1;
        I1 = 1'b1;
        step(LAT);
        chk("sim_o0_up", O0, 1'b1);
        chk("sim_o1_up", O1, 1'b1);
        o0_low = 1'b0;
        I0 = 1'b0;
        I1 = 1'b0;
        step(5);
        I0 = 1'b1;
        step(LAT - 6);
        chk("ind_o1_pre", O1, 1'b1);
        step(1);
        chk("ind_o1_fall", O1, 1'b0);
        chk("ind_o0_hold", o0_low, 1'b0);
        I1 = 1'b1;
        step(LAT + 1);
        chk("ind_o1_up", O1, 1'b1);

        // 5. Reset mid-count discards progress.
        I0 = 1'b0;
        step(10);
        rst_n = 1'b0;
        #1;
        chk("midrst_o0", O0, 1'b1);
        step(1);
        rst_n = 1'b1;
        step(LAT - 1);
        chk("midrst_o0_pre", O0, 1'b1);
        step(1);
        chk("midrst_o0_fall", O0, 1'b0);
        chk("midrst_o1_hold", O1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
